// File: rtl/sliced_adder_pkg.sv
// Shared types and helpers for the pipelined, carry-sliced adder/subtractor.
// Default geometry is 16-bit operands resolved four bits per stage.
package sliced_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;

  typedef logic [DEFAULT_SLICE-1:0] slice_t;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } add_mode_e;

  // Pipeline depth: one stage per slice.
  function automatic int num_slices(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered SLICE-bit add stage: sums an operand slice plus carry-in and
// holds the sum slice, carry-out and stage valid bit until the pipeline advances.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o
);

  logic [SLICE:0]   total;
  logic             valid_d;
  logic             valid_q;
  logic [SLICE-1:0] sum_d;
  logic [SLICE-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  always_comb begin
    total   = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
    valid_d = valid_i;
    sum_d   = total[SLICE-1:0];
    cout_d  = total[SLICE];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: rtl/sliced_adder_pipe.sv
// Pipelined carry-sliced adder/subtractor, one slice resolved per stage.
// Define SLICED_ADDER_OVF_EN to add the signed-overflow output out_ovf.
module sliced_adder_pipe
  import sliced_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
`ifdef SLICED_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NS   = num_slices(WIDTH, SLICE);
  localparam int LAST = NS - 1;

  // Handshake: a beat transfers on either side only in a cycle where valid
  // and ready are both high. The whole pipeline moves as one (advance) when
  // the output slot is empty or being drained; in_ready is exactly advance,
  // so it never depends on in_valid.
  logic             advance;
  add_mode_e        mode;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin
    advance = !out_valid || out_ready;
    mode    = add_mode_e'(in_sub);
    b_eff   = (mode == SUB) ? ~in_b : in_b;
    cin_eff = (mode == SUB) ? 1'b1 : in_cin;
  end

  assign in_ready = advance;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * SLICE;
    localparam int RES_W = (k + 1) * SLICE;

    // src_*: operand bits not yet consumed when this stage computes.
    logic [SRC_W-1:0] src_a;
    logic [SRC_W-1:0] src_b;
    logic             src_cin;
    logic             src_valid;
    logic             v_out;
    logic             cout;
    logic [SLICE-1:0] sum_sl;
    logic [RES_W-1:0] res;

    if (k == 0) begin : g_src
      always_comb begin
        src_a     = in_a;
        src_b     = b_eff;
        src_cin   = cin_eff;
        src_valid = in_valid;
      end
    end else begin : g_src
      always_comb begin
        src_a     = g_stage[k-1].g_fwd.a_q;
        src_b     = g_stage[k-1].g_fwd.b_q;
        src_cin   = g_stage[k-1].cout;
        src_valid = g_stage[k-1].v_out;
      end
    end

    adder_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .valid_i (src_valid),
      .a_i     (src_a[SLICE-1:0]),
      .b_i     (src_b[SLICE-1:0]),
      .cin_i   (src_cin),
      .valid_o (v_out),
      .sum_o   (sum_sl),
      .cout_o  (cout)
    );

    // Higher operand slices ride along, skewed one stage per slice.
    if (k < LAST) begin : g_fwd
      logic [SRC_W-SLICE-1:0] a_d;
      logic [SRC_W-SLICE-1:0] a_q;
      logic [SRC_W-SLICE-1:0] b_d;
      logic [SRC_W-SLICE-1:0] b_q;

      always_comb begin
        a_d = src_a[SRC_W-1:SLICE];
        b_d = src_b[SRC_W-1:SLICE];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Already-resolved lower result slices travel with the beat.
    if (k == 0) begin : g_res
      assign res = sum_sl;
    end else begin : g_res
      logic [RES_W-SLICE-1:0] lo_d;
      logic [RES_W-SLICE-1:0] lo_q;

      always_comb begin
        lo_d = g_stage[k-1].res;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          lo_q <= '0;
        end else if (advance) begin
          lo_q <= lo_d;
        end
      end

      assign res = {sum_sl, lo_q};
    end

`ifdef SLICED_ADDER_OVF_EN
    // Same-sign operands producing an opposite-sign MSB is exactly
    // carry-into-MSB XOR carry-out-of-MSB for the top slice.
    if (k == LAST) begin : g_ovf
      logic [SLICE-1:0] top_sum;
      logic             ovf_d;
      logic             ovf_q;

      always_comb begin
        top_sum = src_a[SLICE-1:0] + src_b[SLICE-1:0] + {{(SLICE-1){1'b0}}, src_cin};
        ovf_d   = (src_a[SLICE-1] ~^ src_b[SLICE-1]) & (top_sum[SLICE-1] ^ src_a[SLICE-1]);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[LAST].v_out;
  assign out_sum   = g_stage[LAST].res;
  assign out_carry = g_stage[LAST].cout;

`ifdef SLICED_ADDER_OVF_EN
  assign out_ovf = g_stage[LAST].g_ovf.ovf_q;
`endif

  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_carry)));

endmodule
